// File: rtl/sm3_arb_ctrl.sv
// Two-requester arbiter/sequencer in front of a single 32-bit-input SM3 core.
// A grant spans a whole message plus its result handshake; re-arbitration happens only in IDLE.
module sm3_arb_ctrl #(
  parameter int unsigned INPT_DW = 32,
  parameter bit          FAIR_RR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [INPT_DW-1:0]   req0_d,
  input  logic [INPT_DW/8-1:0] req0_vld_byte,
  input  logic                 req0_vld,
  input  logic                 req0_lst,
  output logic                 req0_rdy,
  output logic [255:0]         req0_res,
  output logic                 req0_res_vld,
  input  logic                 req0_res_rdy,

  input  logic [INPT_DW-1:0]   req1_d,
  input  logic [INPT_DW/8-1:0] req1_vld_byte,
  input  logic                 req1_vld,
  input  logic                 req1_lst,
  output logic                 req1_rdy,
  output logic [255:0]         req1_res,
  output logic                 req1_res_vld,
  input  logic                 req1_res_rdy,

  output logic [INPT_DW-1:0]   core_msg_d,
  output logic [INPT_DW/8-1:0] core_msg_vld_byte,
  output logic                 core_msg_vld,
  output logic                 core_msg_lst,
  input  logic                 core_msg_rdy,
  input  logic [255:0]         core_res,
  input  logic                 core_res_vld,

  output logic                 busy,
  output logic                 gnt_id,
  output logic [31:0]          word_cnt,
  output logic                 err_spurious
);

  typedef enum logic [1:0] {StIdle, StXfer, StWaitRes, StOut} state_e;

  state_e       state_q, state_d;
  logic         gnt_q, gnt_d;
  logic         ptr_q, ptr_d;
  logic [255:0] res_q, res_d;
  logic [31:0]  word_cnt_q, word_cnt_d;
  logic         err_q, err_d;

  // Signals of whichever requester currently holds the grant
  logic [INPT_DW-1:0]   g_d;
  logic [INPT_DW/8-1:0] g_vld_byte;
  logic                 g_vld, g_lst, g_res_rdy;
  logic                 beat_acc;

  assign g_d        = gnt_q ? req1_d        : req0_d;
  assign g_vld_byte = gnt_q ? req1_vld_byte : req0_vld_byte;
  assign g_vld      = gnt_q ? req1_vld      : req0_vld;
  assign g_lst      = gnt_q ? req1_lst      : req0_lst;
  assign g_res_rdy  = gnt_q ? req1_res_rdy  : req0_res_rdy;
  assign beat_acc   = (state_q == StXfer) & g_vld & core_msg_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      ptr_q      <= 1'b0;
      res_q      <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      res_q      <= res_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    res_d      = res_q;
    word_cnt_d = word_cnt_q;
    // A result pulse is only meaningful while a message is outstanding
    err_d      = err_q | (core_res_vld & (state_q != StWaitRes));
    unique case (state_q)
      StIdle: begin
        if (req0_vld | req1_vld) begin
          if (req0_vld & req1_vld) gnt_d = FAIR_RR ? ptr_q : 1'b0;
          else                     gnt_d = req1_vld;
          word_cnt_d = '0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (beat_acc) begin
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 32'd1;
          if (g_lst) state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        if (core_res_vld) begin
          res_d   = core_res;
          state_d = StOut;
        end
      end
      StOut: begin
        if (g_res_rdy) begin
          ptr_d   = ~gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic xfer, out;
    xfer              = (state_q == StXfer);
    out               = (state_q == StOut);
    core_msg_d        = xfer ? g_d        : '0;
    core_msg_vld_byte = xfer ? g_vld_byte : '0;
    core_msg_vld      = xfer & g_vld;
    core_msg_lst      = xfer & g_lst;
    req0_rdy          = xfer & ~gnt_q & core_msg_rdy;
    req1_rdy          = xfer &  gnt_q & core_msg_rdy;
    req0_res_vld      = out & ~gnt_q;
    req1_res_vld      = out &  gnt_q;
    req0_res          = res_q;
    req1_res          = res_q;
    busy              = (state_q != StIdle);
    gnt_id            = gnt_q;
    word_cnt          = word_cnt_q;
    err_spurious      = err_q;
  end

endmodule
